seq_symbol_tx: RTL and testbench
================================

# seq_symbol_tx

Transmitter for the 2-bit symbol stream consumed by the 01→10→11 sequence detector. On a start request it emits a programmable number of complete frames (symbols 01, 10, 11) separated by a fixed number of idle 00 symbols, one symbol per clock. It drives detector inputs in loopback benches and any datapath that must produce detector-matching traffic. It reports progress through busy/done handshakes and a frame counter.

## Interface

- CNT_W, 4, width of the frame-count request and of the frames_sent counter (legal range 2..8)
- GAP, 1, number of 00 idle symbols inserted between consecutive frames (legal range 0..3)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when idle
- frames  in  CNT_W  number of frames to send; sampled together with start
- abort  in  1  cancel an in-progress transfer
- num  out  2  current symbol (registered)
- num_valid  out  1  high while num carries a frame or gap symbol
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- frames_sent  out  CNT_W  frames completed in the current or most recent transfer

## Operation

- States: IDLE, S01, S10, S11, GAP.
- Symbol driven per state: IDLE 00 (num_valid=0); S01 01; S10 10; S11 11; GAP 00 (num_valid=1 in all non-IDLE states).
- IDLE: start=1 and frames≠0 → S01; latch frames into a remaining-frames counter; clear frames_sent to 0; busy=1 from the next cycle.
- IDLE: start=1 and frames=0 → stay IDLE; done pulses next cycle; frames_sent cleared to 0; no symbols emitted.
- S01 → S10 → S11 unconditionally (absent abort).
- Leaving S11: frames_sent increments by 1 (saturation not needed, bounded by frames). If remaining frames after this one = 0 → IDLE with done=1 for one cycle. Otherwise → GAP if GAP>0, else directly to S01.
- GAP: holds for exactly GAP cycles (internal 2-bit gap counter reloaded on entry), then → S01.
- start while busy: ignored; frames input not re-sampled.
- abort=1 in any non-IDLE state → IDLE next cycle; num=00, num_valid=0, busy=0; done NOT pulsed; frames_sent retains frames completed so far. abort in IDLE: no effect. abort has priority over all other transitions.
- start and abort in the same IDLE cycle: start wins (abort ignored in IDLE).
- Reset (reset_n=0, any time including mid-transfer): immediately IDLE, num=00, num_valid=0, busy=0, done=0, frames_sent=0, internal counters 0.
- Loopback property: a detector fed num (with 00 while idle) asserts its match output once per frame, first in the cycle after the 11 symbol; match stays high through gap symbols and drops when the next 01 is sampled.

## Timing

- All outputs registered; no combinational path from inputs to outputs.
- Latency: start accepted at edge k → num=01, num_valid=1, busy=1 in cycle k+1.
- Transfer length for N frames: 3N + GAP·(N−1) cycles of busy=1.
- done asserts in the first cycle after the final 11, coincident with busy=0 and num=00; width exactly one cycle.
- A new start is accepted in the same cycle done is high (back-to-back transfers with one idle cycle).
- frames_sent updates in the cycle after the corresponding 11 symbol.
- Reset values: num=00, num_valid=0, busy=0, done=0, frames_sent=0.

## Test plan

- GAP=1, frames=3, start pulse: num sequence 01,10,11,00,01,10,11,00,01,10,11 then 00; busy high 11 cycles; done one pulse; frames_sent=3; loopback detector fires 3 times.
- GAP=0, frames=2: num 01,10,11,01,10,11; busy 6 cycles; done after last 11; frames_sent steps 1 then 2.
- frames=0 with start: no num_valid, busy stays 0, done pulses one cycle later, frames_sent=0.
- frames=4, abort asserted during the second frame's 10 symbol: next cycle num=00, busy=0, done never asserted, frames_sent=1; start asserted during the transfer before abort had no effect.
- reset_n driven low mid-GAP of a frames=5 transfer: outputs go to reset values without waiting for clk; after release, start with frames=1 gives 01,10,11 and frames_sent=1.
- start held high continuously with frames=1, GAP=2: transfers repeat with exactly one idle cycle (done cycle) between them; each produces 01,10,11.

Source files
------------

// File: rtl/seq_symbol_tx.sv
// Symbol-stream transmitter producing 01,10,11 frames separated by GAP idle 00
// symbols, with busy/done handshakes and a completed-frame counter.
module seq_symbol_tx #(
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic             abort,
  output logic [1:0]       num,
  output logic             num_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S01  = 3'd1,
    ST_S10  = 3'd2,
    ST_S11  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [1:0]       GAP_LOAD = 2'(GAP);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] remaining_r;
  logic [1:0]       gap_cnt_r;

  // Frame sequencer; every output is assigned from the next-state decision so it is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= CNT_ZERO;
      gap_cnt_r   <= 2'd0;
      num         <= 2'b00;
      num_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= CNT_ZERO;
    end else begin
      done <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        // Cancel keeps frames_sent so software can see how far the transfer got.
        state_r     <= ST_IDLE;
        remaining_r <= CNT_ZERO;
        gap_cnt_r   <= 2'd0;
        num         <= 2'b00;
        num_valid   <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              frames_sent <= CNT_ZERO;
              if (frames != CNT_ZERO) begin
                state_r     <= ST_S01;
                remaining_r <= frames;
                num         <= 2'b01;
                num_valid   <= 1'b1;
                busy        <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_S01: begin
            state_r <= ST_S10;
            num     <= 2'b10;
          end
          ST_S10: begin
            state_r <= ST_S11;
            num     <= 2'b11;
          end
          ST_S11: begin
            frames_sent <= frames_sent + CNT_ONE;
            remaining_r <= remaining_r - CNT_ONE;
            if (remaining_r == CNT_ONE) begin
              state_r   <= ST_IDLE;
              num       <= 2'b00;
              num_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (GAP_LOAD != 2'd0) begin
              state_r   <= ST_GAP;
              gap_cnt_r <= GAP_LOAD;
              num       <= 2'b00;
            end else begin
              state_r <= ST_S01;
              num     <= 2'b01;
            end
          end
          ST_GAP: begin
            if (gap_cnt_r <= 2'd1) begin
              state_r   <= ST_S01;
              gap_cnt_r <= 2'd0;
              num       <= 2'b01;
            end else begin
              gap_cnt_r <= gap_cnt_r - 2'd1;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            remaining_r <= CNT_ZERO;
            gap_cnt_r   <= 2'd0;
            num         <= 2'b00;
            num_valid   <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_symbol_tx.sv
// Directed bench for seq_symbol_tx: three instances (GAP=1, GAP=0, GAP=2) share
// clock, reset, frames and abort; each has its own start.
module tb_seq_symbol_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] frames;
  logic       abort;
  logic       start1, start0, start2;

  logic [1:0] num1, num0, num2;
  logic       val1, val0, val2;
  logic       busy1, busy0, busy2;
  logic       done1, done0, done2;
  logic [3:0] fs1, fs0, fs2;

  int checks   = 0;
  int failures = 0;
  int det1     = 0;
  logic [5:0] hist1 = 6'd0;

  seq_symbol_tx #(.CNT_W(4), .GAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .frames(frames), .abort(abort),
    .num(num1), .num_valid(val1), .busy(busy1), .done(done1), .frames_sent(fs1));

  seq_symbol_tx #(.CNT_W(4), .GAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .frames(frames), .abort(abort),
    .num(num0), .num_valid(val0), .busy(busy0), .done(done0), .frames_sent(fs0));

  seq_symbol_tx #(.CNT_W(4), .GAP(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .frames(frames), .abort(abort),
    .num(num2), .num_valid(val2), .busy(busy2), .done(done2), .frames_sent(fs2));

  always #5 clk = ~clk;

  // Loopback model of the 01->10->11 detector watching instance 1.
  always @(posedge clk) begin
    hist1 <= {hist1[3:0], num1};
    if ({hist1[3:0], num1} == 6'b01_10_11) det1 <= det1 + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] e1 [11] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [3:0] f1 [11] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
  logic [1:0] e0 [6]  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
  logic [3:0] f0 [6]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
  logic [1:0] e2 [8]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] er [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    reset_n = 1'b0; frames = 4'd0; abort = 1'b0;
    start1 = 1'b0; start0 = 1'b0; start2 = 1'b0;
    #3;
    chk("rst_num",  {6'd0, num1},  8'd0);
    chk("rst_val",  {7'd0, val1},  8'd0);
    chk("rst_busy", {7'd0, busy1}, 8'd0);
    chk("rst_done", {7'd0, done1}, 8'd0);
    chk("rst_fs",   {4'd0, fs1},   8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // GAP=1, three frames
    frames = 4'd3; start1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      start1 = 1'b0;
      chk($sformatf("g1_num%0d", i),  {6'd0, num1},  {6'd0, e1[i]});
      chk($sformatf("g1_busy%0d", i), {7'd0, busy1}, 8'd1);
      chk($sformatf("g1_val%0d", i),  {7'd0, val1},  8'd1);
      chk($sformatf("g1_fs%0d", i),   {4'd0, fs1},   {4'd0, f1[i]});
      chk($sformatf("g1_done%0d", i), {7'd0, done1}, 8'd0);
    end
    tick();
    chk("g1_end_num",  {6'd0, num1},  8'd0);
    chk("g1_end_busy", {7'd0, busy1}, 8'd0);
    chk("g1_end_val",  {7'd0, val1},  8'd0);
    chk("g1_end_done", {7'd0, done1}, 8'd1);
    chk("g1_end_fs",   {4'd0, fs1},   8'd3);
    chk("g1_detect",   det1[7:0],     8'd3);
    tick();
    chk("g1_done_drop", {7'd0, done1}, 8'd0);

    // GAP=0, two frames back to back
    frames = 4'd2; start0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start0 = 1'b0;
      chk($sformatf("g0_num%0d", i),  {6'd0, num0},  {6'd0, e0[i]});
      chk($sformatf("g0_busy%0d", i), {7'd0, busy0}, 8'd1);
      chk($sformatf("g0_fs%0d", i),   {4'd0, fs0},   {4'd0, f0[i]});
    end
    tick();
    chk("g0_end_done", {7'd0, done0}, 8'd1);
    chk("g0_end_busy", {7'd0, busy0}, 8'd0);
    chk("g0_end_fs",   {4'd0, fs0},   8'd2);

    // zero-frame request: done only
    frames = 4'd0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("z_done", {7'd0, done1}, 8'd1);
    chk("z_busy", {7'd0, busy1}, 8'd0);
    chk("z_val",  {7'd0, val1},  8'd0);
    chk("z_fs",   {4'd0, fs1},   8'd0);
    tick();
    chk("z_done_drop", {7'd0, done1}, 8'd0);
    chk("z_val2",      {7'd0, val1},  8'd0);

    // frames=4, start re-asserted mid-transfer, abort in second frame's 10
    frames = 4'd4; start1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) frames = 4'd7;
      if (i == 3) start1 = 1'b0;
      chk($sformatf("ab_num%0d", i), {6'd0, num1}, {6'd0, e1[i]});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_num",  {6'd0, num1},  8'd0);
    chk("ab_val",  {7'd0, val1},  8'd0);
    chk("ab_busy", {7'd0, busy1}, 8'd0);
    chk("ab_done", {7'd0, done1}, 8'd0);
    chk("ab_fs",   {4'd0, fs1},   8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ab_idle_done%0d", i), {7'd0, done1}, 8'd0);
      chk($sformatf("ab_idle_busy%0d", i), {7'd0, busy1}, 8'd0);
    end

    // asynchronous reset during a gap of a five-frame transfer
    frames = 4'd5; start1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start1 = 1'b0;
    end
    chk("ar_in_gap", {6'd0, num1}, 8'd0);
    chk("ar_fs_pre", {4'd0, fs1},  8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_busy", {7'd0, busy1}, 8'd0);
    chk("ar_val",  {7'd0, val1},  8'd0);
    chk("ar_fs",   {4'd0, fs1},   8'd0);
    chk("ar_num",  {6'd0, num1},  8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    frames = 4'd1; start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      start1 = 1'b0;
      chk($sformatf("ar_post_num%0d", i), {6'd0, num1}, {6'd0, e1[i]});
    end
    tick();
    chk("ar_post_done", {7'd0, done1}, 8'd1);
    chk("ar_post_fs",   {4'd0, fs1},   8'd1);

    // GAP=2, two frames: two idle symbols between frames
    frames = 4'd2; start2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start2 = 1'b0;
      chk($sformatf("g2_num%0d", i),  {6'd0, num2},  {6'd0, e2[i]});
      chk($sformatf("g2_busy%0d", i), {7'd0, busy2}, 8'd1);
    end
    tick();
    chk("g2_end_done", {7'd0, done2}, 8'd1);
    chk("g2_end_fs",   {4'd0, fs2},   8'd2);

    // start held high with frames=1: repeating transfers, one idle (done) cycle apart
    frames = 4'd1; start2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rep_num%0d", i),  {6'd0, num2},  {6'd0, er[i % 4]});
      chk($sformatf("rep_done%0d", i), {7'd0, done2}, {7'd0, (i % 4) == 3});
      chk($sformatf("rep_busy%0d", i), {7'd0, busy2}, {7'd0, (i % 4) != 3});
    end
    start2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
